// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode and ALU codes,
// FSM state encoding and the decoded control word.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_INC  = 6'h03;
  localparam logic [5:0] OP_DEC  = 6'h04;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_XOR  = 6'h07;
  localparam logic [5:0] OP_NOT  = 6'h08;
  localparam logic [5:0] OP_SLL  = 6'h09;
  localparam logic [5:0] OP_SRL  = 6'h0A;
  localparam logic [5:0] OP_ADDI = 6'h0B;
  localparam logic [5:0] OP_SUBI = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h22;
  localparam logic [5:0] OP_SW   = 6'h24;

  localparam logic [3:0] ALU_NOT = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_DEC = 4'b0100;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_INC = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [3:0] alu_control;
    logic       shamt_sel;
    logic       is_load;
    logic       is_store;
    logic       legal;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '{reg_dst: 1'b0, alu_src: 1'b0, alu_control: 4'b0000,
                                     shamt_sel: 1'b0, is_load: 1'b0, is_store: 1'b0,
                                     legal: 1'b0};

  // Register-destination ALU operation with optional immediate / shift-amount source.
  function automatic ctrl_word_t alu_word(input logic [3:0] code, input logic imm,
                                          input logic sh);
    ctrl_word_t cw;
    cw = '{reg_dst: 1'b1, alu_src: imm, alu_control: code, shamt_sel: sh,
           is_load: 1'b0, is_store: 1'b0, legal: 1'b1};
    return cw;
  endfunction

  // Memory operation: address is base + offset, so ALU adds with the immediate.
  function automatic ctrl_word_t mem_word(input logic load);
    ctrl_word_t cw;
    cw = '{reg_dst: 1'b0, alu_src: 1'b1, alu_control: ALU_ADD, shamt_sel: 1'b0,
           is_load: load, is_store: ~load, legal: 1'b1};
    return cw;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Handshake and datapath-control bundle between the controller (master) and
// datapath/memory (slave). The illegal flag exists only with CTRL_ILLEGAL_TRAP_EN.
interface multicycle_controller_if #(
  parameter int OPCODE_W   = 6,
  parameter int ALU_CTRL_W = 4
);
  logic                  en;
  logic [OPCODE_W-1:0]   opcode;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  ir_write;
  logic                  i_or_d;
  logic                  mem_read;
  logic                  mem_write;
  logic                  reg_dst;
  logic                  reg_write;
  logic                  alu_src;
  logic                  mem_to_reg;
  logic                  shamt_sel;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  instr_done;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  illegal;

  modport master (
    input  en, opcode, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
           alu_src, mem_to_reg, shamt_sel, alu_control, instr_done, illegal
  );
  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
           alu_src, mem_to_reg, shamt_sel, alu_control, instr_done, illegal
  );
`else
  modport master (
    input  en, opcode, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
           alu_src, mem_to_reg, shamt_sel, alu_control, instr_done
  );
  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
           alu_src, mem_to_reg, shamt_sel, alu_control, instr_done
  );
`endif
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode to the control word. Any set bit
// above the six-bit encoding field makes the opcode illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          cw
);

  logic upper_nz_s;
  assign upper_nz_s = ((opcode >> 6) != {OPCODE_W{1'b0}});

  // Opcode to control-word lookup
  always_comb begin
    cw = CW_NONE;
    if (upper_nz_s) begin
      cw = CW_NONE;
    end else begin
      case (opcode[5:0])
        OP_ADD:  cw = alu_word(ALU_ADD, 1'b0, 1'b0);
        OP_ADDI: cw = alu_word(ALU_ADD, 1'b1, 1'b0);
        OP_SUB:  cw = alu_word(ALU_SUB, 1'b0, 1'b0);
        OP_SUBI: cw = alu_word(ALU_SUB, 1'b1, 1'b0);
        OP_INC:  cw = alu_word(ALU_INC, 1'b0, 1'b0);
        OP_DEC:  cw = alu_word(ALU_DEC, 1'b0, 1'b0);
        OP_AND:  cw = alu_word(ALU_AND, 1'b0, 1'b0);
        OP_OR:   cw = alu_word(ALU_OR,  1'b0, 1'b0);
        OP_XOR:  cw = alu_word(ALU_XOR, 1'b0, 1'b0);
        OP_NOT:  cw = alu_word(ALU_NOT, 1'b0, 1'b0);
        OP_SLL:  cw = alu_word(ALU_SLL, 1'b0, 1'b1);
        OP_SRL:  cw = alu_word(ALU_SRL, 1'b0, 1'b1);
        OP_LW:   cw = mem_word(1'b1);
        OP_SW:   cw = mem_word(1'b0);
        default: cw = CW_NONE;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multi-cycle control FSM sharing one memory port for fetch and data.
// Optional CTRL_ILLEGAL_TRAP_EN adds a TRAP state and a sticky illegal flag.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ALU_CTRL_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = ST_TRAP;
`endif

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [OPCODE_W-1:0] opcode_r;
  logic [OPCODE_W-1:0] opcode_sel_s;
  ctrl_word_t          cw_s;

  logic       pc_write_s, ir_write_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       reg_dst_s, reg_write_s, alu_src_s, mem_to_reg_s, shamt_sel_s;
  logic       instr_done_s;
  logic [3:0] alu_code_s;

  // DECODE looks at the live field so the branch to EXEC is known that cycle;
  // every later state uses the latched copy.
  assign opcode_sel_s = (state_r == S_DECODE) ? bus.opcode : opcode_r;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (opcode_sel_s),
    .cw     (cw_s)
  );

  // State register and opcode latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_FETCH;
      opcode_r <= {OPCODE_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) begin
        opcode_r <= bus.opcode;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if ((state_r == S_DECODE) && !cw_s.legal) begin
      illegal_r <= 1'b1;
    end
  end

  assign bus.illegal = illegal_r & ~rst;
`endif

  // Next-state and state-gated control outputs
  always_comb begin
    state_nxt_s  = state_r;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    i_or_d_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    shamt_sel_s  = 1'b0;
    instr_done_s = 1'b0;
    alu_code_s   = 4'b0000;
    if (rst) begin
      state_nxt_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (bus.en) begin
            mem_read_s = 1'b1;
            if (bus.mem_ready) begin
              ir_write_s  = 1'b1;
              pc_write_s  = 1'b1;
              state_nxt_s = S_DECODE;
            end else begin
              state_nxt_s = S_FETCH;
            end
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_DECODE: begin
          if (cw_s.legal) begin
            state_nxt_s = S_EXEC;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt_s = S_TRAP;
`else
            state_nxt_s = S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          alu_code_s  = cw_s.alu_control;
          alu_src_s   = cw_s.alu_src;
          shamt_sel_s = cw_s.shamt_sel;
          if (cw_s.is_load || cw_s.is_store) begin
            state_nxt_s = S_MEM;
          end else begin
            state_nxt_s = S_WB;
          end
        end
        S_MEM: begin
          // Address comes from the ALU, so its controls stay put for the access.
          alu_code_s  = cw_s.alu_control;
          alu_src_s   = cw_s.alu_src;
          shamt_sel_s = cw_s.shamt_sel;
          i_or_d_s    = 1'b1;
          mem_read_s  = cw_s.is_load;
          mem_write_s = cw_s.is_store;
          if (bus.mem_ready) begin
            if (cw_s.is_store) begin
              instr_done_s = 1'b1;
              state_nxt_s  = S_FETCH;
            end else begin
              state_nxt_s  = S_WB;
            end
          end else begin
            state_nxt_s = S_MEM;
          end
        end
        S_WB: begin
          alu_code_s   = cw_s.alu_control;
          alu_src_s    = cw_s.alu_src;
          shamt_sel_s  = cw_s.shamt_sel;
          reg_write_s  = 1'b1;
          instr_done_s = 1'b1;
          reg_dst_s    = cw_s.reg_dst;
          mem_to_reg_s = ~cw_s.is_load;
          state_nxt_s  = S_FETCH;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP: begin
          state_nxt_s = S_TRAP;
        end
`endif
        default: begin
          state_nxt_s = S_FETCH;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.i_or_d      = i_or_d_s;
  assign bus.mem_read    = mem_read_s;
  assign bus.mem_write   = mem_write_s;
  assign bus.reg_dst     = reg_dst_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.alu_src     = alu_src_s;
  assign bus.mem_to_reg  = mem_to_reg_s;
  assign bus.shamt_sel   = shamt_sel_s;
  assign bus.instr_done  = instr_done_s;
  assign bus.alu_control = ALU_CTRL_W'(alu_code_s);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (OPCODE_W = 8).
// Per-cycle expected output words are queued with the stimulus and popped at sampling.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPCODE_W(8), .ALU_CTRL_W(4)) bus ();

  multicycle_controller #(.OPCODE_W(8), .ALU_CTRL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Output word layout: [15] illegal [14] pc_write [13] ir_write [12] i_or_d
  // [11] mem_read [10] mem_write [9] reg_dst [8] reg_write [7] alu_src
  // [6] mem_to_reg [5] shamt_sel [4] instr_done [3:0] alu_control
  localparam logic [15:0] Z   = 16'h0000;
  localparam logic [15:0] IL  = 16'h8000;
  localparam logic [15:0] PCW = 16'h4000;
  localparam logic [15:0] IRW = 16'h2000;
  localparam logic [15:0] IOD = 16'h1000;
  localparam logic [15:0] MR  = 16'h0800;
  localparam logic [15:0] MW  = 16'h0400;
  localparam logic [15:0] RD  = 16'h0200;
  localparam logic [15:0] RW  = 16'h0100;
  localparam logic [15:0] AS  = 16'h0080;
  localparam logic [15:0] M2R = 16'h0040;
  localparam logic [15:0] SH  = 16'h0020;
  localparam logic [15:0] DN  = 16'h0010;
  localparam logic [15:0] FT  = MR | IRW | PCW;
  localparam logic [15:0] WBA = RW | DN | RD | M2R;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [15:0] observed();
    logic il;
`ifdef CTRL_ILLEGAL_TRAP_EN
    il = bus.illegal;
`else
    il = 1'b0;
`endif
    return {il, bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.reg_dst, bus.reg_write, bus.alu_src, bus.mem_to_reg, bus.shamt_sel,
            bus.instr_done, bus.alu_control};
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare on the falling edge.
  task automatic cyc(input logic r, input logic e, input logic [7:0] op, input logic rdy,
                     input logic [15:0] exp, input string tag);
    logic [15:0] o;
    logic [15:0] x;
    string       t;
    rst           = r;
    bus.en        = e;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    o = observed();
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, x);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.opcode    = 8'h00;
    bus.mem_ready = 1'b0;

    // Outputs forced low while reset is held, even with en and mem_ready high
    cyc(1'b1, 1'b1, 8'h01, 1'b1, Z, "rst_out0");
    cyc(1'b1, 1'b1, 8'h01, 1'b1, Z, "rst_out1");

    // ADD, zero wait: retire on 4th cycle; opcode changed after DECODE must not matter
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                "add_fetch");
    cyc(1'b0, 1'b1, 8'h01, 1'b1, Z,                 "add_dec");
    cyc(1'b0, 1'b1, 8'h3F, 1'b1, 16'h0005,          "add_exec");
    cyc(1'b0, 1'b1, 8'h3F, 1'b1, WBA | 16'h0005,    "add_wb");
    cyc(1'b0, 1'b0, 8'h00, 1'b1, Z,                 "idle");

    // LW with two wait cycles in FETCH and in MEM: retire on 9th cycle
    cyc(1'b0, 1'b1, 8'h00, 1'b0, MR,                      "lw_fwait1");
    cyc(1'b0, 1'b1, 8'h00, 1'b0, MR,                      "lw_fwait2");
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                      "lw_fetch");
    cyc(1'b0, 1'b1, 8'h22, 1'b0, Z,                       "lw_dec");
    cyc(1'b0, 1'b1, 8'h01, 1'b0, AS | 16'h0005,           "lw_exec");
    cyc(1'b0, 1'b1, 8'h01, 1'b0, IOD | MR | AS | 16'h0005, "lw_mwait1");
    cyc(1'b0, 1'b1, 8'h01, 1'b0, IOD | MR | AS | 16'h0005, "lw_mwait2");
    cyc(1'b0, 1'b1, 8'h01, 1'b1, IOD | MR | AS | 16'h0005, "lw_mem");
    cyc(1'b0, 1'b1, 8'h01, 1'b0, RW | DN | AS | 16'h0005,  "lw_wb");

    // SW: done coincides with mem_ready in MEM, no reg_write
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                            "sw_fetch");
    cyc(1'b0, 1'b1, 8'h24, 1'b1, Z,                             "sw_dec");
    cyc(1'b0, 1'b1, 8'h24, 1'b1, AS | 16'h0005,                 "sw_exec");
    cyc(1'b0, 1'b1, 8'h24, 1'b0, IOD | MW | AS | 16'h0005,      "sw_mwait");
    cyc(1'b0, 1'b1, 8'h24, 1'b1, IOD | MW | AS | DN | 16'h0005, "sw_mem");
    cyc(1'b0, 1'b0, 8'h24, 1'b1, Z,                             "sw_idle");

    // SLL then SRL
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                    "sll_fetch");
    cyc(1'b0, 1'b1, 8'h09, 1'b1, Z,                     "sll_dec");
    cyc(1'b0, 1'b1, 8'h09, 1'b1, SH | 16'h0009,         "sll_exec");
    cyc(1'b0, 1'b1, 8'h09, 1'b1, WBA | SH | 16'h0009,   "sll_wb");
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                    "srl_fetch");
    cyc(1'b0, 1'b1, 8'h0A, 1'b1, Z,                     "srl_dec");
    cyc(1'b0, 1'b1, 8'h0A, 1'b1, SH | 16'h000A,         "srl_exec");
    cyc(1'b0, 1'b1, 8'h0A, 1'b1, WBA | SH | 16'h000A,   "srl_wb");

    // SUBI: immediate source selected
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                    "subi_fetch");
    cyc(1'b0, 1'b1, 8'h0C, 1'b1, Z,                     "subi_dec");
    cyc(1'b0, 1'b1, 8'h0C, 1'b1, AS | 16'h0006,         "subi_exec");
    cyc(1'b0, 1'b1, 8'h0C, 1'b1, WBA | AS | 16'h0006,   "subi_wb");

    // Illegal 3F
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT, "ill3f_fetch");
    cyc(1'b0, 1'b1, 8'h3F, 1'b1, Z,  "ill3f_dec");
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc(1'b0, 1'b1, 8'h00, 1'b1, IL, "ill3f_trap1");
    cyc(1'b0, 1'b1, 8'h00, 1'b1, IL, "ill3f_trap2");
    cyc(1'b1, 1'b1, 8'h00, 1'b1, Z,  "ill3f_rst");
`else
    cyc(1'b0, 1'b1, 8'h00, 1'b0, MR, "ill3f_back_fetch");
`endif

    // 0x41: low bits look like ADD, but an upper bit is set
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT, "ill41_fetch");
    cyc(1'b0, 1'b1, 8'h41, 1'b1, Z,  "ill41_dec");
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc(1'b0, 1'b1, 8'h00, 1'b1, IL, "ill41_trap");
    cyc(1'b1, 1'b1, 8'h00, 1'b1, Z,  "ill41_rst");
`else
    cyc(1'b0, 1'b1, 8'h00, 1'b0, MR, "ill41_back_fetch");
`endif

    // Reset during MEM of LW aborts the load
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                       "rlw_fetch");
    cyc(1'b0, 1'b1, 8'h22, 1'b1, Z,                        "rlw_dec");
    cyc(1'b0, 1'b1, 8'h22, 1'b1, AS | 16'h0005,            "rlw_exec");
    cyc(1'b0, 1'b1, 8'h22, 1'b0, IOD | MR | AS | 16'h0005, "rlw_mwait");
    cyc(1'b1, 1'b1, 8'h22, 1'b1, Z,                        "rlw_rst");
    cyc(1'b0, 1'b1, 8'h22, 1'b0, MR,                       "rlw_post_fetch");
    cyc(1'b0, 1'b0, 8'h22, 1'b1, Z,                        "rlw_post_idle1");
    cyc(1'b0, 1'b0, 8'h22, 1'b1, Z,                        "rlw_post_idle2");

    // en dropped mid-instruction: XOR still completes, then idle
    cyc(1'b0, 1'b1, 8'h00, 1'b1, FT,                 "xor_fetch");
    cyc(1'b0, 1'b0, 8'h07, 1'b0, Z,                  "xor_dec");
    cyc(1'b0, 1'b0, 8'h07, 1'b0, 16'h0002,           "xor_exec");
    cyc(1'b0, 1'b0, 8'h07, 1'b0, WBA | 16'h0002,     "xor_wb");
    cyc(1'b0, 1'b0, 8'h07, 1'b1, Z,                  "xor_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the MIPS-basic datapath. It replaces the single-cycle opcode decoder with a five-state FSM (FETCH, DECODE, EXEC, MEM, WB) that shares one memory port for instructions and data. Memory accesses wait on a ready handshake, and the opcode and ALU-control widths are parameters. It sits between the instruction register/opcode field and the datapath muxes, register file, ALU and shared memory.

## Interface
- `OPCODE_W`, default 6: opcode width. Must be ≥ 6. Encodings are zero-extended; any nonzero upper bit means the opcode is illegal.
- `ALU_CTRL_W`, default 4: ALU control width. Must be ≥ 4. Codes are zero-extended.
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  run enable. Sampled only in FETCH.
- `opcode`  in  OPCODE_W  opcode field of the instruction register. Valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current request in this cycle.
- `pc_write`  out  1  PC update strobe.
- `ir_write`  out  1  instruction register load strobe.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `mem_read`, `mem_write`  out  1 each  memory request.
- `reg_dst`, `reg_write`, `alu_src`, `mem_to_reg`, `shamt_sel`  out  1 each  datapath controls. `mem_to_reg` = 1 selects the ALU result; 0 selects memory data.
- `alu_control`  out  ALU_CTRL_W  ALU operation code.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  sticky illegal-opcode flag. Present only with `CTRL_ILLEGAL_TRAP_EN`.

## Operation
- Opcode encodings and the corresponding ALU codes:
  - ADD = 01 and ADDI = 0B use ALU code 0101.
  - SUB = 02 and SUBI = 0C use 0110.
  - INC = 03 uses 0111. DEC = 04 uses 0100.
  - AND = 05 uses 0001. OR = 06 uses 0011. XOR = 07 uses 0010. NOT = 08 uses 0000.
  - SLL = 09 uses 1001 with `shamt_sel` = 1. SRL = 0A uses 1010 with `shamt_sel` = 1.
  - LW = 22 and SW = 24 use 0101 with `alu_src` = 1.
  - `alu_src` = 1 for ADDI, SUBI, LW and SW.
- Opcode latch: on the DECODE cycle the opcode is latched into an internal register. Changes on `opcode` after DECODE have no effect.
- FETCH:
  - `en` = 0: idle; all outputs are 0.
  - `en` = 1: `mem_read` = 1 and `i_or_d` = 0, held until `mem_ready`.
  - In the `mem_ready` cycle, `ir_write` = 1 and `pc_write` = 1 (Mealy outputs), then go to DECODE.
- DECODE: one cycle, no strobes.
  - Legal opcode: go to EXEC.
  - Illegal opcode: go to FETCH with no writes, or to TRAP with the macro enabled.
- EXEC: one cycle. Drives `alu_control`, `alu_src` and `shamt_sel` from the latched opcode.
  - LW and SW go to MEM.
  - All other legal opcodes go to WB.
- MEM:
  - `i_or_d` = 1; `mem_read` (LW) or `mem_write` (SW) is held until `mem_ready`. ALU controls stay stable.
  - LW: on `mem_ready`, go to WB.
  - SW: on `mem_ready`, `instr_done` = 1 and go to FETCH.
- WB: one cycle.
  - `reg_write` = 1 and `instr_done` = 1.
  - `reg_dst` = 1 and `mem_to_reg` = 1 for ALU ops.
  - `reg_dst` = 0 and `mem_to_reg` = 0 for LW.
  - Then go to FETCH.
- Every output not named for the current state is 0.
- `mem_read` and `mem_write` are never asserted together.
- `reg_write` is asserted only in WB.

## Timing
- Reset:
  - While `rst` = 1, every output is 0 and the next state is FETCH.
  - `illegal` clears to 0.
  - Reset in any state, including MEM with a request pending, aborts the instruction; no write strobe is issued afterwards.
- Zero-wait latency (`mem_ready` tied to 1), FETCH entry to `instr_done`:
  - ALU op: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Illegal opcode: 2 cycles, then back in FETCH with no retire.
- Wait states: each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle. Requests remain asserted and stable throughout the wait.
- `mem_ready` outside FETCH or MEM is ignored.
- `en` deasserted mid-instruction does not stall. The instruction completes, and the FSM then idles in FETCH.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE enters TRAP.
  - `illegal` = 1 from the next cycle until `rst`.
  - TRAP drives all other outputs to 0 and leaves only on reset.
- Not defined:
  - There is no `illegal` port and no TRAP state.
  - An illegal opcode returns to FETCH silently; the PC has already advanced.

## Structure
- Shared package `ctrl_pkg` holds:
  - the opcode constants;
  - the ALU control code constants;
  - the state enum;
  - a control-word struct (`reg_dst`, `alu_src`, `alu_control`, `shamt_sel`, `is_load`, `is_store`, `legal`).
- One combinational sub-module, `ctrl_decode`, maps the latched opcode to the control word. The FSM in `multicycle_controller` gates that word by state.

## Test plan
- ADD (01), `mem_ready` = 1, `en` = 1: `reg_write` pulse 4 cycles after FETCH entry, with `alu_control` = 0101 in EXEC and WB, and `mem_to_reg` = 1.
- LW (22) with 2 wait cycles in both FETCH and MEM:
  - `instr_done` arrives after 9 cycles.
  - `mem_read` and `i_or_d` are stable during the waits.
  - In WB, `reg_dst` = 0 and `mem_to_reg` = 0.
- SW (24): `mem_write` = 1 and `i_or_d` = 1 in MEM. `reg_write` is never asserted. `instr_done` coincides with `mem_ready` in MEM.
- SLL (09) then SRL (0A): `shamt_sel` = 1 with `alu_control` 1001 for SLL, then 1010 for SRL.
- Illegal opcode (3F), and opcode 41 with `OPCODE_W` = 8:
  - Without the macro: back to FETCH after 2 cycles with no strobes.
  - With the macro: `illegal` = 1 and held until `rst`.
- `rst` pulsed in MEM of an LW: no `reg_write` afterwards. Outputs are 0 during reset. FETCH `mem_read` = 1 on the first cycle after release with `en` = 1.
